// File: rtl/osf_pkg.sv
// Shared sizing, phase encoding and config helpers for the ADC oversample filter.
package osf_pkg;
  localparam int W_DATA      = 18;
  localparam int N_CHAN      = 6;
  localparam int W_CHAN      = 3;
  localparam int MAX_LOG_OVR = 15;
  localparam int W_DELAY     = 16;
  localparam int W_LOG       = 4;
  localparam int W_ACC       = W_DATA + MAX_LOG_OVR;
  localparam int W_CNT       = MAX_LOG_OVR + 1;

  typedef enum logic {SKIP = 1'b0, ACCUM = 1'b1} phase_e;

  function automatic logic [W_LOG-1:0] clamp_log(input logic [W_LOG-1:0] v);
    return ({1'b0, v} > 5'(MAX_LOG_OVR)) ? W_LOG'(MAX_LOG_OVR) : v;
  endfunction

  // A zero settling delay means the channel starts accumulating immediately.
  function automatic phase_e entry_phase(input logic [W_DELAY-1:0] d);
    return (d == '0) ? ACCUM : SKIP;
  endfunction
endpackage

// File: rtl/adc_osf_shift.sv
// Scales an accumulated window down to one sample: arithmetic shift by log_ovr.
// OSF_ROUND_EN selects round-half-up; otherwise rounds toward negative infinity.
module adc_osf_shift
  import osf_pkg::*;
(
  input  logic signed [W_ACC-1:0] acc_i,
  input  logic [W_LOG-1:0]        log_ovr_i,
  output logic [W_DATA-1:0]       data_o
);
  logic signed [W_ACC:0] biased;

`ifdef OSF_ROUND_EN
  logic [W_ACC:0] half;
  always_comb begin
    half = '0;
    if (log_ovr_i != '0) half = (W_ACC+1)'(1) << (log_ovr_i - W_LOG'(1));
  end
  assign biased = {acc_i[W_ACC-1], acc_i} + signed'(half);
`else
  assign biased = {acc_i[W_ACC-1], acc_i};
`endif

  // The average of 2^log_ovr in-range samples always fits W_DATA.
  assign data_o = W_DATA'(biased >>> log_ovr_i);
endmodule

// File: rtl/adc_osf.sv
// Time-multiplexed per-channel settle/average/decimate filter after the ADC controller.
// Build option OSF_ROUND_EN (in adc_osf_shift) enables round-half-up averaging.
module adc_osf
  import osf_pkg::*;
(
  input  logic                clk_in,
  input  logic                n_rst_in,
  input  logic                data_valid_in,
  input  logic [W_CHAN-1:0]   chan_in,
  input  logic [W_DATA-1:0]   data_in,
  input  logic [N_CHAN-1:0]   activate_in,
  input  logic [W_DELAY-1:0]  cycle_delay_in,
  input  logic [W_LOG-1:0]    log_ovr_in,
  input  logic [N_CHAN-1:0]   update_en_in,
  input  logic                module_update_in,
  output logic                data_valid_out,
  output logic [W_CHAN-1:0]   chan_out,
  output logic [W_DATA-1:0]   data_out
);
  logic signed [W_ACC-1:0] acc_q   [N_CHAN];
  logic signed [W_ACC-1:0] acc_d   [N_CHAN];
  logic [W_CNT-1:0]        cnt_q   [N_CHAN];
  logic [W_CNT-1:0]        cnt_d   [N_CHAN];
  logic [W_DELAY-1:0]      skip_q  [N_CHAN];
  logic [W_DELAY-1:0]      skip_d  [N_CHAN];
  logic [W_DELAY-1:0]      dly_q   [N_CHAN];
  logic [W_DELAY-1:0]      dly_d   [N_CHAN];
  logic [W_LOG-1:0]        log_q   [N_CHAN];
  logic [W_LOG-1:0]        log_d   [N_CHAN];
  phase_e                  phase_q [N_CHAN];
  phase_e                  phase_d [N_CHAN];

  logic                vld_q, vld_d;
  logic [W_CHAN-1:0]   chan_q, chan_d;
  logic [W_DATA-1:0]   data_q, data_d;

  logic [W_CHAN-1:0]       sel;
  logic signed [W_ACC-1:0] samp_ext;
  logic signed [W_ACC-1:0] sum;
  logic [W_DATA-1:0]       avg;

  // Only one channel is touched per cycle, so a single adder/shifter serves all.
  assign sel      = (chan_in < W_CHAN'(N_CHAN)) ? chan_in : '0;
  assign samp_ext = {{MAX_LOG_OVR{data_in[W_DATA-1]}}, data_in};
  assign sum      = acc_q[sel] + samp_ext;

  adc_osf_shift u_shift (
    .acc_i     (sum),
    .log_ovr_i (log_q[sel]),
    .data_o    (avg)
  );

  always_comb begin
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    skip_d  = skip_q;
    dly_d   = dly_q;
    log_d   = log_q;
    phase_d = phase_q;
    vld_d   = 1'b0;
    chan_d  = chan_q;
    data_d  = data_q;
    for (int c = 0; c < N_CHAN; c++) begin
      // Commit beats a same-cycle sample on that channel; the sample is dropped.
      if (module_update_in && update_en_in[c]) begin
        dly_d[c]   = cycle_delay_in;
        log_d[c]   = clamp_log(log_ovr_in);
        acc_d[c]   = '0;
        cnt_d[c]   = '0;
        skip_d[c]  = cycle_delay_in;
        phase_d[c] = entry_phase(cycle_delay_in);
      end else if (!activate_in[c]) begin
        acc_d[c]   = '0;
        cnt_d[c]   = '0;
        skip_d[c]  = dly_q[c];
        phase_d[c] = entry_phase(dly_q[c]);
      end else if (data_valid_in && chan_in == W_CHAN'(c)) begin
        if (phase_q[c] == SKIP) begin
          if (skip_q[c] <= W_DELAY'(1)) phase_d[c] = ACCUM;
          else                          skip_d[c]  = skip_q[c] - W_DELAY'(1);
        end else if (cnt_q[c] + W_CNT'(1) == (W_CNT'(1) << log_q[c])) begin
          vld_d      = 1'b1;
          chan_d     = chan_in;
          data_d     = avg;
          acc_d[c]   = '0;
          cnt_d[c]   = '0;
          skip_d[c]  = dly_q[c];
          phase_d[c] = entry_phase(dly_q[c]);
        end else begin
          acc_d[c] = sum;
          cnt_d[c] = cnt_q[c] + W_CNT'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge n_rst_in) begin
    if (!n_rst_in) begin
      for (int c = 0; c < N_CHAN; c++) begin
        acc_q[c]   <= '0;
        cnt_q[c]   <= '0;
        skip_q[c]  <= '0;
        dly_q[c]   <= '0;
        log_q[c]   <= '0;
        phase_q[c] <= ACCUM;
      end
      vld_q  <= 1'b0;
      chan_q <= '0;
      data_q <= '0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      skip_q  <= skip_d;
      dly_q   <= dly_d;
      log_q   <= log_d;
      phase_q <= phase_d;
      vld_q   <= vld_d;
      chan_q  <= chan_d;
      data_q  <= data_d;
    end
  end

  assign data_valid_out = vld_q;
  assign chan_out       = chan_q;
  assign data_out       = data_q;
endmodule

// File: tb/tb_adc_osf.sv
// Directed scoreboard bench for adc_osf: expected outputs queued at stimulus time.
module tb_adc_osf;
  logic        clk_in = 1'b0;
  logic        n_rst_in = 1'b0;
  logic        data_valid_in = 1'b0;
  logic [2:0]  chan_in = '0;
  logic [17:0] data_in = '0;
  logic [5:0]  activate_in = '0;
  logic [15:0] cycle_delay_in = '0;
  logic [3:0]  log_ovr_in = '0;
  logic [5:0]  update_en_in = '0;
  logic        module_update_in = 1'b0;
  logic        data_valid_out;
  logic [2:0]  chan_out;
  logic [17:0] data_out;

  adc_osf dut (
    .clk_in(clk_in), .n_rst_in(n_rst_in), .data_valid_in(data_valid_in),
    .chan_in(chan_in), .data_in(data_in), .activate_in(activate_in),
    .cycle_delay_in(cycle_delay_in), .log_ovr_in(log_ovr_in),
    .update_en_in(update_en_in), .module_update_in(module_update_in),
    .data_valid_out(data_valid_out), .chan_out(chan_out), .data_out(data_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [2:0]  chan;
    logic [17:0] data;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  function automatic int avg(input int s, input int lg);
`ifdef OSF_ROUND_EN
    return (s + ((lg > 0) ? (1 << (lg - 1)) : 0)) >>> lg;
`else
    return s >>> lg;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d required=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int ch, input int d);
    exp_t e;
    e.chan = 3'(ch);
    e.data = 18'(d);
    e.cyc  = cyc + 1;
    sb.push_back(e);
  endtask

  // Advance one clock and check any output against the scoreboard.
  task automatic tick;
    exp_t e;
    @(posedge clk_in);
    #1;
    cyc++;
    if (data_valid_out === 1'b1) begin
      total++;
      assert (sb.size() > 0) else begin
        bad++;
        $error("FAIL unexpected_out observed chan=%0d data=%0d required=none", chan_out, data_out);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("out_chan", 32'(chan_out), 32'(e.chan));
        chk("out_data", 32'(data_out), 32'(e.data));
        chk("out_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  endtask

  task automatic step(input logic dv, input int ch, input int d,
                      input logic mu, input logic [5:0] en, input int dly, input int lg);
    data_valid_in    = dv;
    chan_in          = 3'(ch);
    data_in          = 18'(d);
    module_update_in = mu;
    update_en_in     = en;
    cycle_delay_in   = 16'(dly);
    log_ovr_in       = 4'(lg);
    tick();
    data_valid_in    = 1'b0;
    module_update_in = 1'b0;
    update_en_in     = '0;
  endtask

  task automatic send(input int ch, input int d);
    step(1'b1, ch, d, 1'b0, 6'h00, 0, 0);
  endtask

  task automatic commit(input logic [5:0] en, input int dly, input int lg);
    step(1'b0, 0, 0, 1'b1, en, dly, lg);
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_valid", 32'(data_valid_out), 32'd0);
    chk("rst_chan", 32'(chan_out), 32'd0);
    chk("rst_data", 32'(data_out), 32'd0);
    tick(); tick();
    n_rst_in = 1'b1;
    activate_in = 6'h3F;
    tick();

    // Four-sample average on ch0
    commit(6'h01, 0, 2);
    send(0, 1111); send(0, 4444); send(0, 17776);
    push(0, avg(94435, 2));
    send(0, 71104);
    tick();
    chk("hold_valid", 32'(data_valid_out), 32'd0);
    chk("hold_data", 32'(data_out), 32'(18'(avg(94435, 2))));

    // Negative rounding
    commit(6'h01, 0, 1);
    send(0, -3);
    push(0, avg(-5, 1));
    send(0, -2);

    // Settling delay with pass-through
    commit(6'h02, 2, 0);
    send(1, 10); send(1, 20);
    push(1, 30); send(1, 30);
    send(1, 40); send(1, 50);
    push(1, 60); send(1, 60);
    tick();

    // Commit collides with a sample; other channels unaffected
    commit(6'h08, 0, 0);
    commit(6'h01, 0, 2);
    push(3, 9);
    step(1'b1, 3, 9, 1'b1, 6'h01, 0, 2);
    send(0, 8);
    step(1'b1, 0, 1000, 1'b1, 6'h01, 0, 2);
    send(0, 4);
    push(3, 7); send(3, 7);
    send(0, 8); send(0, 12);
    push(0, avg(40, 2));
    send(0, 16);

    // Deactivation discards the partial window
    send(0, 500); send(0, 500); send(0, 500);
    activate_in = 6'h3E;
    tick();
    activate_in = 6'h3F;
    send(0, 100); send(0, 100); send(0, 100);
    push(0, 100);
    send(0, 100);

    // Asynchronous reset mid-window
    send(0, 7); send(0, 7);
    chk("pre_rst_data", 32'(data_out), 32'd100);
    #2;
    n_rst_in = 1'b0;
    #1;
    chk("async_valid", 32'(data_valid_out), 32'd0);
    chk("async_chan", 32'(chan_out), 32'd0);
    chk("async_data", 32'(data_out), 32'd0);
    tick(); tick();
    n_rst_in = 1'b1;
    push(0, 1234); send(0, 1234);
    push(5, -77);  send(5, -77);
    send(6, 555);
    send(7, 1);
    tick(); tick();

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/adc_osf.md
# adc_osf

Time-multiplexed oversample filter directly downstream of the ADC serial controller. Consumes the per-channel 18-bit samples the controller emits after each conversion, discards a programmable number of settling samples, averages 2^log_ovr samples per channel and emits one decimated sample per channel to the PID/router stage. Per-channel configuration is staged from front-panel wire-ins and committed on the module-update trigger.

## Interface
- W_DATA, 18, sample width, two's complement
- N_CHAN, 6, number of ADC channels
- W_CHAN, 3, channel index width
- MAX_LOG_OVR, 15, largest supported log2 oversample ratio
- W_DELAY, 16, cycle-delay counter width
- clk_in  in  1  system clock
- n_rst_in  in  1  asynchronous active-low reset
- data_valid_in  in  1  one-cycle strobe, sample present on data_in/chan_in
- chan_in  in  W_CHAN  channel index of sample
- data_in  in  W_DATA  signed sample
- activate_in  in  N_CHAN  live per-channel enable
- cycle_delay_in  in  W_DELAY  staged samples to discard after each output/commit
- log_ovr_in  in  4  staged log2 oversample ratio
- update_en_in  in  N_CHAN  channels that take staged config on commit
- module_update_in  in  1  one-cycle commit strobe
- data_valid_out  out  1  one-cycle strobe
- chan_out  out  W_CHAN  channel of output sample
- data_out  out  W_DATA  signed decimated sample

## Operation
- Per-channel state: accumulator (W_DATA+MAX_LOG_OVR signed), sample count (MAX_LOG_OVR+1 bits), skip counter (W_DELAY), committed log_ovr and cycle_delay.
- Per-channel phase: SKIP (discarding) or ACCUM. Reset and commit enter SKIP with skip counter = cycle_delay; cycle_delay 0 goes directly to ACCUM.
- Sample on channel c with activate_in[c]=1:
  - SKIP: decrement skip counter; at 1 → ACCUM next sample. Sample dropped.
  - ACCUM: acc += sign-extended data_in, count++. When count reaches 2^log_ovr: emit acc+sample >>> log_ovr (arithmetic), clear acc and count, enter SKIP with cycle_delay (or stay ACCUM if 0).
- log_ovr=0: every accumulated sample passes through unchanged.
- log_ovr_in > MAX_LOG_OVR clamped to MAX_LOG_OVR at commit.
- activate_in[c]=0: samples ignored; acc, count cleared, phase reset to SKIP with cycle_delay; config retained.
- chan_in >= N_CHAN: sample ignored, no state change.
- Commit: on module_update_in, every c with update_en_in[c]=1 latches cycle_delay/log_ovr and clears its acc/count, enters SKIP. Channels with update_en_in[c]=0 untouched.
- Sample and commit on same cycle for same channel: commit wins, sample dropped. Other channels process normally.
- Result truncated to W_DATA; averaging guarantees it fits.

## Timing
- Reset values: data_valid_out 0, chan_out 0, data_out 0; all accumulators/counts 0; log_ovr 0, cycle_delay 0, phase ACCUM.
- Latency: data_valid_out asserts exactly one clk_in after the data_valid_in completing the window; chan_out/data_out valid with it and held until next output.
- Accepts data_valid_in every cycle; no back-pressure, no input buffering.
- Reset asserted mid-window: all state and outputs to reset values asynchronously; partial window lost.

## Configuration
- OSF_ROUND_EN defined: add 2^(log_ovr-1) (0 when log_ovr=0) before the shift, round-half-up.
- Undefined: pure arithmetic shift, round toward negative infinity.

## Structure
- Package osf_pkg: W_DATA, N_CHAN, W_CHAN, MAX_LOG_OVR, W_DELAY, derived accumulator width constant, phase enum {SKIP, ACCUM}.
- One sub-module adc_osf_shift: combinational (optionally rounding) arithmetic shift of accumulator by log_ovr to W_DATA; per-channel state kept as arrays in adc_osf.

## Test plan
- Reset, ch0 commit log_ovr=2 delay=0, active; samples 1111, 4444, 17776, 71104 -> single output ch0 = 23608 (23609 with OSF_ROUND_EN), one cycle after fourth strobe.
- ch0 log_ovr=1, samples -3, -2 -> output -3 (-2 with OSF_ROUND_EN).
- ch1 delay=2 log_ovr=0, samples 10,20,30,40,50,60 -> outputs 30 and 60 only.
- Commit on ch0 same cycle as its 2nd of 4 samples -> that sample dropped, next output needs 4 fresh samples; ch3 interleaved with log_ovr=0 still emits each sample.
- activate_in[0] dropped after 3 of 4 samples, re-raised, 4 samples of 100 -> output 100, no contamination.
- Assert n_rst_in after 2 of 4 samples -> outputs 0 immediately; config back to log_ovr 0, next sample passes through.
